// File: rtl/sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : sched_pkg                                                      |
// | Purpose : Shared scheduler-path types and defaults. The ingress queue,   |
// |           the round-robin arbiter and the dispatch stage all import      |
// |           these, so port count and payload width stay consistent.        |
// | Contents: SCHED_NUM_PORTS, SCHED_DATA_W, PORT_IDX_W, job_t               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package sched_pkg;

    localparam int SCHED_NUM_PORTS = 4;
    localparam int SCHED_DATA_W    = 8;
    localparam int PORT_IDX_W      = $clog2(SCHED_NUM_PORTS);

    // A job as it travels from ingress to dispatch: payload plus source port.
    typedef struct packed {
        logic [SCHED_DATA_W-1:0] data;
        logic [PORT_IDX_W-1:0]   port;
    } job_t;

endpackage : sched_pkg
`default_nettype wire

// File: rtl/sched_port_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sched_port_fifo                                                |
// | Purpose : Single-push / single-pop FIFO for one ingress port. Control    |
// |           state (pointers, count) resets asynchronously; the storage     |
// |           array does not, since a zero count hides whatever it holds.    |
// | Ports   : clk, rst_n       - clock, async active-low reset               |
// |           push, push_data  - write request and payload                   |
// |           pop              - advance read pointer                        |
// |           head             - entry at the read pointer                   |
// |           count            - occupancy 0..DEPTH                          |
// |           full, empty      - occupancy flags                             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sched_port_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Guard against over/underflow even if the caller misbehaves.
    assign do_push = push & ~full;
    assign do_pop  = pop  & ~empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : sched_port_fifo
`default_nettype wire

// File: rtl/sched_ingress_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sched_ingress_queue                                            |
// | Purpose : Per-port ingress FIFOs feeding the scheduler arbiter, with a   |
// |           single registered valid/ready output slot toward dispatch.     |
// | Ports   : clk, rst_n    - clock, async active-low reset                  |
// |           in_valid_i    - per-port push request                          |
// |           in_data_i     - per-port payload, port p at [p*DATA_W+:DATA_W] |
// |           in_ready_o    - per-port FIFO not full                         |
// |           req_o         - request vector to the arbiter                  |
// |           gnt_i         - grant vector from the arbiter                  |
// |           out_valid_o   - output slot holds a job                        |
// |           out_data_o    - job payload                                    |
// |           out_port_o    - source port of the job                         |
// |           out_ready_i   - downstream accepts the job                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sched_ingress_queue
    import sched_pkg::*;
#(
    parameter int NUM_PORTS = SCHED_NUM_PORTS,
    parameter int DATA_W    = SCHED_DATA_W,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS-1:0]         in_valid_i,
    input  logic [NUM_PORTS*DATA_W-1:0]  in_data_i,
    output logic [NUM_PORTS-1:0]         in_ready_o,
    output logic [NUM_PORTS-1:0]         req_o,
    input  logic [NUM_PORTS-1:0]         gnt_i,
    output logic                         out_valid_o,
    output logic [DATA_W-1:0]            out_data_o,
    output logic [$clog2(NUM_PORTS)-1:0] out_port_o,
    input  logic                         out_ready_i
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [DATA_W-1:0]    head  [NUM_PORTS];
    logic [CNT_W-1:0]     count [NUM_PORTS];
    logic                 slot_free;
    logic                 accept;
    logic [IDX_W-1:0]     sel;

    // The slot can take a new job if it is empty or draining this cycle.
    // This makes req_o combinational on out_ready_i by design.
    assign slot_free = ~out_valid_o | out_ready_i;
    assign req_o     = ~empty & {NUM_PORTS{slot_free}};

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            // Ready is taken from the pre-pop count: a full FIFO rejects a
            // push even in the cycle it pops.
            assign in_ready_o[p] = (count[p] != CNT_W'(DEPTH));
            assign push[p]       = in_valid_i[p] & ~full[p];
            assign pop[p]        = accept & (sel == IDX_W'(p));

            sched_port_fifo #(
                .DEPTH  (DEPTH),
                .DATA_W (DATA_W)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push[p]),
                .push_data (in_data_i[p*DATA_W +: DATA_W]),
                .pop       (pop[p]),
                .head      (head[p]),
                .count     (count[p]),
                .full      (full[p]),
                .empty     (empty[p])
            );
        end
    endgenerate

    // Lowest-index grant that matches a live request wins; stray grant bits
    // are ignored so a misbehaving arbiter cannot pop an empty FIFO.
    always_comb begin
        accept = 1'b0;
        sel    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!accept && gnt_i[i] && req_o[i]) begin
                accept = 1'b1;
                sel    = IDX_W'(i);
            end
        end
    end

    // A grant only exists while the slot is free, so loading on accept also
    // covers the transfer-and-reload case for one job per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_port_o  <= '0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= head[sel];
            out_port_o  <= sel;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule : sched_ingress_queue
`default_nettype wire

// File: tb/tb_sched_ingress_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sched_ingress_queue                                         |
// | Purpose : Self-checking bench for sched_ingress_queue. A queue-based     |
// |           reference model tracks per-port contents and the output slot;  |
// |           a small in-bench arbiter answers req_o combinationally.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sched_ingress_queue;
    localparam int NP    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] in_valid_i;
    logic [NP*DW-1:0] in_data_i;
    logic [NP-1:0] in_ready_o;
    logic [NP-1:0] req_o;
    logic [NP-1:0] gnt_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    out_port_o;
    logic          out_ready_i;

    int checks   = 0;
    int failures = 0;

    // Arbiter behaviour: 0 = never grant, 1 = rotating priority one-hot,
    // 2 = all grant bits set (lowest requesting port must win).
    int       gnt_mode = 0;
    logic [1:0] rr_ptr = 2'd0;

    // Reference model
    logic [DW-1:0] mq [NP][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_port;
    logic [DW-1:0] got [$];

    always #5 clk = ~clk;

    sched_ingress_queue #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_port_o  (out_port_o),
        .out_ready_i (out_ready_i)
    );

    always_comb begin
        logic found;
        int   idx;
        gnt_i = '0;
        found = 1'b0;
        idx   = 0;
        if (gnt_mode == 1) begin
            for (int k = 0; k < NP; k++) begin
                idx = (int'(rr_ptr) + k) % NP;
                if (!found && req_o[idx]) begin
                    gnt_i[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end else if (gnt_mode == 2) begin
            gnt_i = '1;
        end
    end

    task automatic model_clear();
        for (int p = 0; p < NP; p++) mq[p].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_port  = '0;
    endtask

    // One clock cycle: called just after a falling edge, returns just after
    // the next falling edge. Outputs are compared against the model before
    // the rising edge; the model is then advanced.
    task automatic cycle(input logic [NP-1:0] v, input logic [NP*DW-1:0] d, input logic rdy);
        logic [NP-1:0] exp_req;
        logic [NP-1:0] exp_rdy;
        logic          sf;
        int            acc;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = rdy;
        rr_ptr      = 2'($urandom_range(0, 3));
        #1;
        sf = !m_valid || rdy;
        for (int p = 0; p < NP; p++) begin
            exp_rdy[p] = (mq[p].size() != DEPTH);
            exp_req[p] = (mq[p].size() != 0) && sf;
        end
        checks++;
        if (in_ready_o !== exp_rdy) begin
            failures++;
            $display("FAIL in_ready: got %b expected %b at %0t", in_ready_o, exp_rdy, $time);
        end
        checks++;
        if (req_o !== exp_req) begin
            failures++;
            $display("FAIL req: got %b expected %b at %0t", req_o, exp_req, $time);
        end
        checks++;
        if (out_valid_o !== m_valid) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid_o, m_valid, $time);
        end
        if (m_valid) begin
            checks++;
            if (out_data_o !== m_data || out_port_o !== m_port) begin
                failures++;
                $display("FAIL out_job: got data %h port %0d expected data %h port %0d at %0t",
                         out_data_o, out_port_o, m_data, m_port, $time);
            end
            if (rdy) got.push_back(out_data_o);
        end
        acc = -1;
        for (int p = 0; p < NP; p++) begin
            if (acc < 0 && gnt_i[p] && exp_req[p]) acc = p;
        end
        @(posedge clk);
        if (acc >= 0) begin
            m_data  = mq[acc].pop_front();
            m_port  = 2'(acc);
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            if (v[p] && exp_rdy[p]) mq[p].push_back(d[p*DW +: DW]);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        gnt_mode = 1;
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1);
    endtask

    task automatic check_got(input string name, input logic [DW-1:0] exp [$]);
        checks++;
        if (got.size() != exp.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d jobs expected %0d", name, got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL %s_order[%0d]: got %h expected %h", name, i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid_i = '0; in_data_i = '0; out_ready_i = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready_o !== 4'b1111 || req_o !== 4'b0000 || out_valid_o !== 1'b0 ||
            out_data_o !== 8'h00 || out_port_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got rdy %b req %b v %b d %h p %0d expected rdy 1111 req 0000 v 0 d 00 p 0",
                     in_ready_o, req_o, out_valid_o, out_data_o, out_port_o);
        end
        rst_n = 1'b1;
        gnt_mode = 1;
        for (int i = 0; i < 10; i++) cycle('0, '0, 1'b0);
    endtask

    task automatic test_latency();
        drain(20);
        gnt_mode = 1;
        cycle(4'b0100, 32'h00A1_0000, 1'b1);
        checks++;
        if (req_o !== 4'b0100) begin
            failures++;
            $display("FAIL latency_req: got %b expected 0100", req_o);
        end
        cycle('0, '0, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hA1 || out_port_o !== 2'd2) begin
            failures++;
            $display("FAIL latency_out: got v %b d %h p %0d expected v 1 d a1 p 2",
                     out_valid_o, out_data_o, out_port_o);
        end
    endtask

    task automatic test_fill_port0();
        logic [DW-1:0] exp [$];
        drain(20);
        gnt_mode = 1;
        cycle(4'b0010, 32'h0000_5500, 1'b0);
        cycle('0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(4'b0001, 32'(8'h10 + i), 1'b0);
        checks++;
        if (in_ready_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got in_ready[0]=%b expected 0", in_ready_o[0]);
        end
        cycle(4'b0001, 32'h0000_0099, 1'b0);
        got.delete();
        for (int i = 0; i < 8; i++) cycle('0, '0, 1'b1);
        exp = '{8'h55, 8'h10, 8'h11, 8'h12, 8'h13};
        check_got("fill", exp);
    endtask

    task automatic test_stall();
        drain(20);
        gnt_mode = 1;
        cycle(4'b1010, 32'h3100_1100, 1'b0);
        cycle(4'b1010, 32'h3200_1200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle('0, '0, 1'b0);
            checks++;
            if (req_o !== 4'b0000 || out_valid_o !== 1'b1 || out_data_o !== m_data) begin
                failures++;
                $display("FAIL stall_hold: got req %b v %b d %h expected req 0000 v 1 d %h",
                         req_o, out_valid_o, out_data_o, m_data);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL stall_b2b[%0d]: got out_valid %b expected 1", i, out_valid_o);
            end
            cycle('0, '0, 1'b1);
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_end: got out_valid %b expected 0", out_valid_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp [$];
        drain(20);
        gnt_mode = 0;
        for (int i = 0; i < DEPTH; i++) cycle(4'b1000, {8'(8'h40 + i), 24'h0}, 1'b1);
        checks++;
        if (in_ready_o[3] !== 1'b0) begin
            failures++;
            $display("FAIL full_before: got in_ready[3]=%b expected 0", in_ready_o[3]);
        end
        got.delete();
        gnt_mode = 1;
        cycle(4'b1000, 32'h7700_0000, 1'b1);
        checks++;
        if (in_ready_o[3] !== 1'b1) begin
            failures++;
            $display("FAIL full_after_pop: got in_ready[3]=%b expected 1", in_ready_o[3]);
        end
        gnt_mode = 0;
        cycle(4'b1000, 32'h7700_0000, 1'b1);
        checks++;
        if (in_ready_o[3] !== 1'b0) begin
            failures++;
            $display("FAIL full_repush: got in_ready[3]=%b expected 0", in_ready_o[3]);
        end
        drain(10);
        exp = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h77};
        check_got("fullpp", exp);
    endtask

    task automatic test_random();
        drain(20);
        for (int i = 0; i < 400; i++) begin
            gnt_mode = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 1);
            cycle(4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_async_reset();
        gnt_mode = 1;
        for (int i = 0; i < 3; i++) cycle(4'b1111, $urandom, 1'b0);
        checks++;
        if (out_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre: got out_valid %b expected 1", out_valid_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || req_o !== 4'b0000 || in_ready_o !== 4'b1111) begin
            failures++;
            $display("FAIL arst_immediate: got v %b req %b rdy %b expected v 0 req 0000 rdy 1111",
                     out_valid_o, req_o, in_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        got.delete();
        for (int i = 0; i < 10; i++) cycle('0, '0, 1'b1);
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL arst_stale: got %0d jobs after reset expected 0", got.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_port0();
        test_stall();
        test_full_push_pop();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sched_ingress_queue
`default_nettype wire
